mdu_sequencer: RTL and testbench
================================

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL provide: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL provide: MDStart  in  1  E-stage strobe; MD instruction issuing this cycle.
REQ-004 SHALL provide: MDSel  in  3  operation: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 0/7 none.
REQ-005 SHALL provide: A  in  32  operand rs (dividend / multiplicand / MT source).
REQ-006 SHALL provide: B  in  32  operand rt (divisor / multiplier).
REQ-007 SHALL provide: MDUse  in  1  D-stage instruction is MD-class (mult/div/mfhi/mflo/mthi/mtlo).
REQ-008 SHALL provide: Busy  out  1  multi-cycle operation in flight.
REQ-009 SHALL provide: Stall  out  1  freeze F/D, bubble E.
REQ-010 SHALL provide: HI  out  32  HI register.
REQ-011 SHALL provide: LO  out  32  LO register.

Function
REQ-012 States SHALL be IDLE and RUN; a 4-bit down-counter Cnt SHALL be held alongside.
REQ-013 IDLE + MDStart with MULT/MULTU SHALL latch the 64-bit product, load Cnt=5, enter RUN.
REQ-014 IDLE + MDStart with DIV/DIVU SHALL latch quotient (to LO) and remainder (to HI), load Cnt=10, enter RUN.
REQ-015 MULT/DIV SHALL be two's-complement signed; MULTU/DIVU unsigned; quotient truncates toward zero, remainder takes dividend sign.
REQ-016 RUN SHALL decrement Cnt each cycle; at Cnt==1 the edge SHALL write pending result to HI/LO and return to IDLE.
REQ-017 Latency: Start sampled at edge k -> Busy=1 in cycles k+1..k+N (N=5 or 10); new HI/LO and Busy=0 visible from cycle k+N+1.
REQ-018 MTHI/MTLO with MDStart in IDLE SHALL write A to HI/LO at that edge, no Busy.
REQ-019 Divisor B==0 SHALL still run 10 cycles and leave HI and LO unchanged.
REQ-020 MDStart with MDSel 0 or 7 SHALL be a no-op.
REQ-021 MDStart while in RUN SHALL be ignored (state, Cnt, pending result unchanged).
REQ-022 Stall SHALL equal MDUse & (Busy | (MDStart & MDSel in {1..4})), combinational.
REQ-023 HI/LO outputs SHALL be registered; no bypass of the pending result.

Reset
REQ-024 reset SHALL force IDLE, Cnt=0, Busy=0, HI=0, LO=0, pending result=0 at next edge, including mid-RUN (result discarded).
REQ-025 reset SHALL dominate MDStart in the same cycle.

Configuration
REQ-026 Macro MDU_DIV_EN SHALL gate division support.
REQ-027 With MDU_DIV_EN defined: DIV/DIVU behave per REQ-014/019.
REQ-028 Without MDU_DIV_EN: MDSel 3/4 SHALL be no-ops (no Busy, no Stall contribution, HI/LO unchanged); no divider logic synthesized.

Structure
REQ-029 Shared package md_pkg SHALL hold MDSel encodings, MULT_LAT=5, DIV_LAT=10, counter width.
REQ-030 Arithmetic SHALL live in sub-module mdu_arith (combinational 64-bit mult/div of A,B per MDSel); mdu_sequencer owns FSM, counter, HI/LO, Stall.

Verification
REQ-031 MULT A=0xFFFFFFFE, B=3 -> Busy 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-032 DIV A=-7 (0xFFFFFFF9), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV B=0 after -> HI/LO unchanged after 10 cycles.
REQ-033 MULT issued, MDUse=1 on cycles k..k+5 -> Stall=1 exactly cycles k..k+5, 0 at k+6; MDUse=0 -> Stall=0 throughout.
REQ-034 MTLO A=0x12345678 in IDLE -> LO=0x12345678 next cycle, Busy=0; MTHI during RUN -> ignored.
REQ-035 reset asserted at Cnt=3 of DIV -> next cycle Busy=0, HI=LO=0, IDLE; new MULT then completes normally.
REQ-036 Build without MDU_DIV_EN: DIVU A=10, B=3 -> Busy=0, Stall=0, HI/LO unchanged.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// sequencer states, latency constants and operation-class helpers.
// Division support is compiled in only when MDU_DIV_EN is defined.
package md_pkg;

    // Operation select encodings carried on MDSel
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_sel_e;

    // Sequencer states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] MULT_LAT = 4'd5;
    localparam logic [CNT_W-1:0] DIV_LAT  = 4'd10;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    // True for the operations that go through the multiplier
    function automatic logic is_mult(input logic [2:0] sel);
        return (sel == MD_MULT) || (sel == MD_MULTU);
    endfunction

    // True for divide operations, but only when division is built in
    function automatic logic is_div(input logic [2:0] sel);
        return DIV_EN && ((sel == MD_DIV) || (sel == MD_DIVU));
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic for the MD unit: 64-bit signed/unsigned product
// and, when MDU_DIV_EN is defined, signed/unsigned quotient and remainder.
// res_wr tells the sequencer whether the result may be committed to HI/LO.
module mdu_arith
    import md_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_wr
);

    logic        mul_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;

    // One multiplier serves both flavours: signed operands are sign-extended,
    // and the low 64 bits of the extended product are the exact result.
    assign mul_signed = (sel == MD_MULT);
    assign a_ext      = {{32{mul_signed & a[31]}}, a};
    assign b_ext      = {{32{mul_signed & b[31]}}, b};
    assign prod       = a_ext * b_ext;

`ifdef MDU_DIV_EN
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero and the remainder follows the dividend. A zero divisor is replaced
    // by one so the divider never sees zero; that result is never committed.
    assign div_signed = (sel == MD_DIV);
    assign a_neg      = div_signed & a[31];
    assign b_neg      = div_signed & b[31];
    assign a_mag      = a_neg ? (~a + 32'd1) : a;
    assign b_mag      = b_neg ? (~b + 32'd1) : b;
    assign b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag      = a_mag / b_safe;
    assign r_mag      = a_mag % b_safe;
    assign quo        = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem        = a_neg ? (~r_mag + 32'd1) : r_mag;
`endif

    // Route the selected operation's result onto the outputs
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b0;
        if (is_mult(sel)) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
            res_wr = 1'b1;
        end
`ifdef MDU_DIV_EN
        else if (is_div(sel)) begin
            res_hi = rem;
            res_lo = quo;
            res_wr = (b != 32'd0);
        end
`endif
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: captures the arithmetic result when an MD
// operation issues, holds Busy for the operation's latency, then commits the
// result to HI/LO. Also handles MTHI/MTLO and generates the pipeline Stall.
// Division is supported only when MDU_DIV_EN is defined.
module mdu_sequencer
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MDStart,
    input  logic [2:0]  MDSel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MDUse,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e          state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [31:0]        hi_q, hi_nxt;
    logic [31:0]        lo_q, lo_nxt;
    logic [31:0]        pend_hi, pend_hi_nxt;
    logic [31:0]        pend_lo, pend_lo_nxt;
    logic               pend_wr, pend_wr_nxt;
    logic [31:0]        arith_hi;
    logic [31:0]        arith_lo;
    logic               arith_wr;
    logic               long_op;

    mdu_arith u_arith (
        .sel    (MDSel),
        .a      (A),
        .b      (B),
        .res_hi (arith_hi),
        .res_lo (arith_lo),
        .res_wr (arith_wr)
    );

    assign long_op = is_mult(MDSel) | is_div(MDSel);

    // State, counter, HI/LO and pending-result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_wr <= pend_wr_nxt;
        end
    end

    // Next-state logic: issue from IDLE, count down in RUN, commit at the end
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hi_nxt      = hi_q;
        lo_nxt      = lo_q;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_wr_nxt = pend_wr;
        case (state)
            ST_IDLE: begin
                if (MDStart) begin
                    if (long_op) begin
                        pend_hi_nxt = arith_hi;
                        pend_lo_nxt = arith_lo;
                        pend_wr_nxt = arith_wr;
                        cnt_nxt     = is_mult(MDSel) ? MULT_LAT : DIV_LAT;
                        state_nxt   = ST_RUN;
                    end else if (MDSel == MD_MTHI) begin
                        hi_nxt = A;
                    end else if (MDSel == MD_MTLO) begin
                        lo_nxt = A;
                    end
                end
            end
            ST_RUN: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt == 4'd1) begin
                    state_nxt = ST_IDLE;
                    if (pend_wr) begin
                        hi_nxt = pend_hi;
                        lo_nxt = pend_lo;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign Busy  = (state == ST_RUN);
    assign Stall = MDUse & (Busy | (MDStart & long_op));
    assign HI    = hi_q;
    assign LO    = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer. A cycle-level behavioural model of
// the MD unit is compared against the DUT on every falling edge, and directed
// cases pin known results. Division cases follow MDU_DIV_EN.
module tb_mdu_sequencer;

    logic        clk;
    logic        reset;
    logic        MDStart;
    logic [2:0]  MDSel;
    logic [31:0] A;
    logic [31:0] B;
    logic        MDUse;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

`ifdef MDU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state: architectural HI/LO, cycles of Busy left, pending result
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;
    bit          p_wr = 1'b0;
    int          m_left = 0;

    mdu_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .MDStart (MDStart),
        .MDSel   (MDSel),
        .A       (A),
        .B       (B),
        .MDUse   (MDUse),
        .Busy    (Busy),
        .Stall   (Stall),
        .HI      (HI),
        .LO      (LO)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h required %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: plain arithmetic on the sampled inputs at each edge
    always @(posedge clk) begin : model
        longint          sp;
        longint unsigned up;
        int              sa;
        int              sb;
        if (reset) begin
            m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_wr = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (MDStart) begin
            case (MDSel)
                3'd1: begin
                    sp = longint'($signed(A)) * longint'($signed(B));
                    {p_hi, p_lo} = sp; p_wr = 1; m_left = 5;
                end
                3'd2: begin
                    up = {32'd0, A} * {32'd0, B};
                    {p_hi, p_lo} = up; p_wr = 1; m_left = 5;
                end
                3'd3: if (DIV_ON) begin
                    m_left = 10;
                    p_wr = (B != 0);
                    if (B != 0) begin
                        sa = $signed(A); sb = $signed(B);
                        p_lo = sa / sb; p_hi = sa % sb;
                    end
                end
                3'd4: if (DIV_ON) begin
                    m_left = 10;
                    p_wr = (B != 0);
                    if (B != 0) begin
                        p_lo = A / B; p_hi = A % B;
                    end
                end
                3'd5: m_hi = A;
                3'd6: m_lo = A;
                default: ;
            endcase
        end
    end

    // Compare DUT outputs to the model on every falling edge
    always @(negedge clk) begin
        bit exp_stall;
        if (chk_en) begin
            exp_stall = MDUse && ((m_left > 0) || (MDStart && (MDSel == 3'd1 || MDSel == 3'd2 ||
                        (DIV_ON && (MDSel == 3'd3 || MDSel == 3'd4)))));
            checkOutput("model_busy",  {31'd0, Busy},  {31'd0, m_left > 0});
            checkOutput("model_stall", {31'd0, Stall}, {31'd0, exp_stall});
            checkOutput("model_hi", HI, m_hi);
            checkOutput("model_lo", LO, m_lo);
        end
    end

    // Drive one MDStart cycle, then drop the strobe
    task automatic applyStimulus(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b, input logic use_);
        @(posedge clk); #1;
        MDStart = 1'b1; MDSel = sel; A = a; B = b; MDUse = use_;
        @(posedge clk); #1;
        MDStart = 1'b0; MDSel = 3'd0;
    endtask

    // Count Busy cycles until Busy drops, bounded by a cycle budget
    task automatic waitIdle(input string name, input int budget, output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!Busy) return;
            busy_cycles++;
        end
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: Busy still high after %0d cycles, required low", name, budget);
    endtask

    initial begin
        int nb;
        int stall_cnt;
        reset = 1'b1; MDStart = 1'b0; MDSel = 3'd0; A = 32'd0; B = 32'd0; MDUse = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        reset  = 1'b0;
        @(negedge clk);
        checkOutput("reset_hi", HI, 32'd0);
        checkOutput("reset_lo", LO, 32'd0);
        checkOutput("reset_busy", {31'd0, Busy}, 32'd0);

        // Signed multiply
        applyStimulus(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        waitIdle("mult_wait", 30, nb);
        checkOutput("mult_busy_cycles", nb, 32'd5);
        checkOutput("mult_hi", HI, 32'hFFFFFFFF);
        checkOutput("mult_lo", LO, 32'hFFFFFFFA);

        // Unsigned multiply, same operands
        applyStimulus(3'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
        waitIdle("multu_wait", 30, nb);
        checkOutput("multu_busy_cycles", nb, 32'd5);
        checkOutput("multu_hi", HI, 32'h00000002);
        checkOutput("multu_lo", LO, 32'hFFFFFFFA);

        // MTLO in IDLE: immediate, no Busy
        applyStimulus(3'd6, 32'h12345678, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("mtlo_lo", LO, 32'h12345678);
        checkOutput("mtlo_busy", {31'd0, Busy}, 32'd0);

        // Stall window with MDUse held: cycles k..k+5 stalled, k+6 free
        @(posedge clk); #1;
        MDStart = 1'b1; MDSel = 3'd1; A = 32'hFFFFFFFD; B = 32'd5; MDUse = 1'b1;
        stall_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 6) stall_cnt += int'(Stall);
            else checkOutput("stall_k6", {31'd0, Stall}, 32'd0);
            @(posedge clk); #1;
            MDStart = 1'b0; MDSel = 3'd0;
        end
        checkOutput("stall_k_to_k5", stall_cnt, 32'd6);
        MDUse = 1'b0;
        @(negedge clk);
        checkOutput("mult_neg_hi", HI, 32'hFFFFFFFF);
        checkOutput("mult_neg_lo", LO, 32'hFFFFFFF1);

        // MTHI during RUN is ignored
        applyStimulus(3'd1, 32'd7, 32'd6, 1'b0);
        applyStimulus(3'd5, 32'hDEADBEEF, 32'd0, 1'b0);
        waitIdle("mthi_run_wait", 30, nb);
        checkOutput("mthi_run_hi", HI, 32'd0);
        checkOutput("mthi_run_lo", LO, 32'h0000002A);

`ifdef MDU_DIV_EN
        // Signed divide -7 / 2
        applyStimulus(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        waitIdle("div_wait", 30, nb);
        checkOutput("div_busy_cycles", nb, 32'd10);
        checkOutput("div_lo", LO, 32'hFFFFFFFD);
        checkOutput("div_hi", HI, 32'hFFFFFFFF);

        // Divide by zero: full latency, HI/LO untouched
        applyStimulus(3'd3, 32'd55, 32'd0, 1'b0);
        waitIdle("div0_wait", 30, nb);
        checkOutput("div0_busy_cycles", nb, 32'd10);
        checkOutput("div0_lo", LO, 32'hFFFFFFFD);
        checkOutput("div0_hi", HI, 32'hFFFFFFFF);

        // Unsigned divide 100 / 7
        applyStimulus(3'd4, 32'd100, 32'd7, 1'b0);
        waitIdle("divu_wait", 30, nb);
        checkOutput("divu_lo", LO, 32'd14);
        checkOutput("divu_hi", HI, 32'd2);

        // Reset while a divide is at count 3
        applyStimulus(3'd3, 32'd100, 32'd7, 1'b0);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_div_busy", {31'd0, Busy}, 32'd0);
        checkOutput("rst_div_hi", HI, 32'd0);
        checkOutput("rst_div_lo", LO, 32'd0);
`else
        // Divide not built: DIVU is a no-op with no Stall contribution
        @(posedge clk); #1;
        MDStart = 1'b1; MDSel = 3'd4; A = 32'd10; B = 32'd3; MDUse = 1'b1;
        @(negedge clk);
        checkOutput("nodiv_stall", {31'd0, Stall}, 32'd0);
        @(posedge clk); #1;
        MDStart = 1'b0; MDSel = 3'd0; MDUse = 1'b0;
        @(negedge clk);
        checkOutput("nodiv_busy", {31'd0, Busy}, 32'd0);
        checkOutput("nodiv_hi", HI, 32'd0);
        checkOutput("nodiv_lo", LO, 32'h0000002A);

        // Reset in the middle of a multiply
        applyStimulus(3'd2, 32'd9, 32'd9, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_mult_busy", {31'd0, Busy}, 32'd0);
        checkOutput("rst_mult_hi", HI, 32'd0);
        checkOutput("rst_mult_lo", LO, 32'd0);
`endif

        // A fresh multiply after reset completes normally
        applyStimulus(3'd1, 32'd7, 32'd6, 1'b0);
        waitIdle("post_rst_wait", 30, nb);
        checkOutput("post_rst_busy_cycles", nb, 32'd5);
        checkOutput("post_rst_lo", LO, 32'h0000002A);
        checkOutput("post_rst_hi", HI, 32'd0);

        repeat (3) @(posedge clk);
        #1 chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
